// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory front-end for the multicycle controller. Each command picks an
//   address (pc or alu_out) and runs one req/ack transaction on the shared
//   instruction/data bus. If no ack arrives within TIMEOUT_CYC cycles the
//   transaction fails. Read data goes to instr (fetch) or mdr (load).
//
// Build option
//   MEM_ALIGN_CHECK_EN  When defined, a command whose selected address has
//                       address[1:0] != 0 goes straight to FAIL and no bus
//                       request is issued.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   pc, alu_out, wdata             fetch address, load/store address, store data
//   addr_src, mem_read, mem_write  controller strobes
//   ir_write                       send read data to instr instead of mdr
//   bus_req, bus_we                bus request and write qualifier
//   bus_addr, bus_wdata            address and data latched for the transaction
//   bus_rdata, bus_ack             read data and one-cycle completion from memory
//   instr, old_pc, mdr             instruction register, its PC, memory data reg
//   busy, done, bus_err            in flight, one-cycle finish pulse, sticky error
//
// state  | meaning
// IDLE   | waiting for a strobe
// REQ    | bus_req high, counting cycles until ack
// ACK_OK | transaction completed, read data captured
// FAIL   | timeout or misaligned address, bus_err set
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    input  logic              addr_src,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ir_write,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] old_pc,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, ACK_OK, FAIL} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              ir_sel;
    logic              cmd;
    logic              misaligned;
    logic [ADDR_W-1:0] sel_addr;

    assign sel_addr = addr_src ? alu_out : pc;
    // A sticky error blocks all further commands until reset.
    assign cmd      = (mem_read | mem_write) & ~bus_err;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (sel_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd) state_next = misaligned ? FAIL : REQ;
            end
            REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_ack)              state_next = ACK_OK;
                else if (cnt == CNT_LAST) state_next = FAIL;
            end
            ACK_OK: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            FAIL: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ir_sel    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            instr     <= '0;
            old_pc    <= '0;
            mdr       <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (state == IDLE && cmd) begin
                // mem_write alone decides the direction, so a write wins over a read.
                bus_addr  <= sel_addr;
                bus_wdata <= wdata;
                bus_we    <= mem_write;
                ir_sel    <= ir_write;
                cnt       <= '0;
            end else if (state == REQ && !bus_ack) begin
                cnt <= cnt + CNT_ONE;
            end

            // Read data is valid only alongside ack, so it is captured on the edge
            // that moves REQ -> ACK_OK.
            if (state == REQ && bus_ack && !bus_we) begin
                if (ir_sel) begin
                    instr  <= bus_rdata;
                    old_pc <= bus_addr;
                end else begin
                    mdr <= bus_rdata;
                end
            end

            if (state_next == FAIL) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0, alu_out = '0, wdata = '0, bus_rdata = '0;
    logic        addr_src = 0, mem_read = 0, mem_write = 0, ir_write = 0, bus_ack = 0;
    logic        bus_req, bus_we, busy, done, bus_err;
    logic [31:0] bus_addr, bus_wdata, instr, old_pc, mdr;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .addr_src(addr_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .instr(instr), .old_pc(old_pc), .mdr(mdr),
        .busy(busy), .done(done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, src, irw, poke;
        logic [31:0] pc, alu, wd, rdata;
        int          dly;   // REQ cycle in which ack is raised; 0 = never
    } vec_t;

    typedef struct {
        logic [31:0] instr, mdr, old_pc;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_instr = '0, m_mdr = '0, m_oldpc = '0;
    logic        m_err = 1'b0;
    int          checks = 0, failures = 0;
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_instr", instr, e.instr);
                chk("sb_mdr", mdr, e.mdr);
                chk("sb_old_pc", old_pc, e.old_pc);
                chk("sb_bus_err", bus_err, e.err);
                chk("sb_busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic model_reset();
        m_instr = '0; m_mdr = '0; m_oldpc = '0; m_err = 1'b0;
        sbq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] a;
        bit          acc, mis;
        int          exp_n, n;
        a   = v.src ? v.alu : v.pc;
        acc = (v.rd || v.wr) && !m_err;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`endif
        exp_n = (!acc || mis) ? 0 : ((v.dly == 0) ? TO : v.dly);
        if (acc) begin
            if (mis || v.dly == 0) m_err = 1'b1;
            else if (!v.wr) begin
                if (v.irw) begin m_instr = v.rdata; m_oldpc = a; end
                else m_mdr = v.rdata;
            end
            sbq.push_back('{m_instr, m_mdr, m_oldpc, m_err});
        end
        @(negedge clk);
        pc = v.pc; alu_out = v.alu; wdata = v.wd; addr_src = v.src;
        mem_read = v.rd; mem_write = v.wr; ir_write = v.irw;
        @(negedge clk);
        mem_read = 0; mem_write = 0; ir_write = 0;
        pc = ~v.pc; alu_out = ~v.alu; wdata = ~v.wd;
        if (v.poke) begin
            mem_read = 1; addr_src = 1; alu_out = 32'h0000_0F00;
        end
        n = 0;
        while (bus_req && n < 40) begin
            chk("busy_in_req", busy, 1'b1);
            chk("bus_we", bus_we, v.wr);
            chk("bus_addr", bus_addr, a);
            chk("bus_wdata", bus_wdata, v.wd);
            n++;
            if (n == v.dly) begin bus_ack = 1; bus_rdata = v.rdata; end
            @(negedge clk);
            bus_ack = 0; bus_rdata = '0; mem_read = 0;
        end
        chk("req_cycles", n, exp_n);
        repeat (2) @(negedge clk);
        chk("no_extra_req", bus_req, 1'b0);
        chk("queue_drained", sbq.size(), 0);
    endtask

    initial begin
        //           rd wr src irw poke  pc            alu           wd            rdata         dly
        vecs[0] = '{1, 0, 0, 1, 0, 32'h40, 32'h0, 32'h0, 32'h0050_0093, 3};
        vecs[1] = '{0, 1, 1, 0, 0, 32'h0, 32'h100, 32'hDEAD_BEEF, 32'h1111_2222, 2};
        vecs[2] = '{1, 0, 1, 0, 1, 32'h0, 32'h200, 32'h0, 32'h0000_1234, 1};
        vecs[3] = '{1, 1, 1, 0, 0, 32'h0, 32'h300, 32'h55AA_55AA, 32'hFFFF_FFFF, 4};
        vecs[4] = '{1, 0, 0, 0, 0, 32'h44, 32'h0, 32'h0, 32'hCAFE_F00D, 5};
        vecs[5] = '{1, 0, 0, 1, 0, 32'h48, 32'h0, 32'h0, 32'h00A0_0113, 2};
        vecs[6] = '{1, 0, 1, 0, 0, 32'h0, 32'h102, 32'h0, 32'h0BAD_BEEF, 2};
        vecs[7] = '{1, 0, 1, 0, 0, 32'h0, 32'h400, 32'h0, 32'h7777_7777, 0};
        vecs[8] = '{1, 0, 1, 0, 0, 32'h0, 32'h500, 32'h0, 32'h8888_8888, 1};

        repeat (2) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_instr", instr, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_bus_err", bus_err, 0);
        rst = 0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Ack outside REQ must not touch any register.
        @(negedge clk);
        bus_ack = 1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_ack = 0; bus_rdata = '0;
        chk("idle_ack_done", done, 0);
        chk("idle_ack_mdr", mdr, m_mdr);
        chk("idle_ack_instr", instr, m_instr);

        for (int i = 5; i < 9; i++) run_vec(vecs[i]);

        // Clear the sticky error, then reset in the middle of a load.
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; model_reset();
        run_vec(vecs[0]);
        run_vec(vecs[4]);
        @(negedge clk);
        alu_out = 32'h600; addr_src = 1; mem_read = 1;
        @(negedge clk);
        mem_read = 0;
        chk("pre_rst_req", bus_req, 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_mdr", mdr, 0);
        chk("mid_rst_bus_err", bus_err, 0);
        model_reset();
        @(negedge clk); rst = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", bus_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
